// File: rtl/button_counter_if.sv
// Key inputs and counter/status outputs of the DE10-Lite button counter controller.
// The controller uses the slave view; the board top or bench uses the master view.
interface button_counter_if;
    logic [1:0] key_n;
    logic [3:0] count;
    logic [1:0] state;
    logic       locked;
    logic       inc_pulse;
    logic [1:0] key_db;

    modport master (
        output key_n,
        input  count,
        input  state,
        input  locked,
        input  inc_pulse,
        input  key_db
    );

    modport slave (
        input  key_n,
        output count,
        output state,
        output locked,
        output inc_pulse,
        output key_db
    );
endinterface

// File: rtl/button_counter_ctrl.sv
// Synchronises and debounces two active-low keys and runs the Increment/Display/Lock FSM
// that owns the single-digit count register.
module button_counter_ctrl #(
    parameter int unsigned TICK_DIV       = 500000,
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned MAX_COUNT      = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    button_counter_if.slave      bus_io
);

    localparam int unsigned TickW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        StIncrement = 2'b00,
        StDisplay   = 2'b01,
        StLock      = 2'b10
    } state_e;

    logic [1:0]       sync1_q, sync2_q;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick;
    logic [1:0][3:0]  stable_q, stable_d;
    logic [1:0]       key_db_q, key_db_d;
    logic [1:0]       key_db_prev_q;
    logic [1:0]       armed_q, armed_d;
    logic [1:0]       press_q;
    state_e           state_q;
    logic [3:0]       count_q;
    logic             locked_q;
    logic             inc_pulse_q;

    assign tick       = (tick_cnt_q == TickW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);

    // A key is armed only once it has been sampled released, so a key held through
    // reset cannot produce a press until it has been let go.
    always_comb begin
        key_db_d = key_db_q;
        stable_d = stable_q;
        armed_d  = armed_q;
        if (tick) begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != key_db_q[i]) begin
                    if (stable_q[i] + 4'd1 == 4'(DEBOUNCE_TICKS)) begin
                        key_db_d[i] = sync2_q[i];
                        stable_d[i] = 4'd0;
                    end else begin
                        stable_d[i] = stable_q[i] + 4'd1;
                    end
                end else begin
                    stable_d[i] = 4'd0;
                    if (sync2_q[i]) armed_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= 2'b11;
            sync2_q       <= 2'b11;
            tick_cnt_q    <= '0;
            stable_q      <= '0;
            key_db_q      <= 2'b11;
            key_db_prev_q <= 2'b11;
            armed_q       <= 2'b00;
            press_q       <= 2'b00;
        end else begin
            sync1_q       <= bus_io.key_n;
            sync2_q       <= sync1_q;
            tick_cnt_q    <= tick_cnt_d;
            stable_q      <= stable_d;
            key_db_q      <= key_db_d;
            key_db_prev_q <= key_db_q;
            armed_q       <= armed_d;
            press_q       <= armed_q & key_db_prev_q & ~key_db_q;
        end
    end

    // Lock/unlock takes priority over increment in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIncrement;
            count_q     <= 4'd0;
            locked_q    <= 1'b0;
            inc_pulse_q <= 1'b0;
        end else begin
            inc_pulse_q <= 1'b0;
            unique case (state_q)
                StIncrement: begin
                    if (press_q[0]) begin
                        state_q  <= StLock;
                        locked_q <= 1'b1;
                    end else if (press_q[1]) begin
                        count_q     <= (count_q == 4'(MAX_COUNT)) ? 4'd0 : count_q + 4'd1;
                        inc_pulse_q <= 1'b1;
                        state_q     <= StDisplay;
                    end
                end
                StDisplay: begin
                    if (press_q[0]) begin
                        state_q  <= StLock;
                        locked_q <= 1'b1;
                    end else if (key_db_q[1]) begin
                        state_q <= StIncrement;
                    end
                end
                StLock: begin
                    if (press_q[0]) begin
                        state_q  <= StIncrement;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StIncrement;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.count     = count_q;
    assign bus_io.state     = state_q;
    assign bus_io.locked    = locked_q;
    assign bus_io.inc_pulse = inc_pulse_q;
    assign bus_io.key_db    = key_db_q;

endmodule

// File: tb/tb_button_counter_ctrl.sv
// Directed bench for button_counter_ctrl with TICK_DIV=4, DEBOUNCE_TICKS=3, MAX_COUNT=9.
module tb_button_counter_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   inc_cnt = 0;
    int   inc_base;
    bit   bounce_phase = 1'b0;
    bit   db_dropped   = 1'b0;

    button_counter_if bus ();

    button_counter_ctrl #(
        .TICK_DIV      (4),
        .DEBOUNCE_TICKS(3),
        .MAX_COUNT     (9)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.inc_pulse) inc_cnt++;
        if (bounce_phase && !bus.key_db[1]) db_dropped = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [1:0] kn);
        bus.key_n = kn;
        step(30);
        bus.key_n = 2'b11;
        step(30);
    endtask

    initial begin
        bus.key_n = 2'b11;
        rst = 1'b1;
        step(3);
        check("rst_count",  32'(bus.count), 0);
        check("rst_state",  32'(bus.state), 0);
        check("rst_locked", 32'(bus.locked), 0);
        check("rst_inc",    32'(bus.inc_pulse), 0);
        check("rst_key_db", 32'(bus.key_db), 3);
        rst = 1'b0;

        // Idle
        step(200);
        check("idle_count", 32'(bus.count), 0);
        check("idle_state", 32'(bus.state), 0);
        check("idle_inc",   32'(inc_cnt), 0);

        // Single increment, KEY1 held 60 cycles
        bus.key_n = 2'b01;
        step(30);
        check("single_state_display", 32'(bus.state), 1);
        check("single_count_held",    32'(bus.count), 1);
        check("single_key_db",        32'(bus.key_db), 1);
        step(30);
        check("single_inc_held", 32'(inc_cnt), 1);
        bus.key_n = 2'b11;
        step(30);
        check("single_state_back", 32'(bus.state), 0);
        check("single_count",      32'(bus.count), 1);
        check("single_inc",        32'(inc_cnt), 1);

        // Wrap from 0 through 9 back to 0
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(10);
        inc_base = inc_cnt;
        for (int i = 0; i < 10; i++) begin
            press(2'b01);
            check($sformatf("wrap_count_%0d", i), 32'(bus.count), 32'((i + 1) % 10));
        end
        check("wrap_inc_total", 32'(inc_cnt - inc_base), 10);

        // Bounce: 5-cycle phases never span three ticks
        inc_base = inc_cnt;
        bounce_phase = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.key_n = (i % 2 == 0) ? 2'b01 : 2'b11;
            step(5);
        end
        bus.key_n = 2'b11;
        step(30);
        bounce_phase = 1'b0;
        check("bounce_db_held", 32'(db_dropped), 0);
        check("bounce_count",   32'(bus.count), 0);
        check("bounce_inc",     32'(inc_cnt - inc_base), 0);

        // Lock / frozen / unlock
        press(2'b10);
        check("lock_state",  32'(bus.state), 2);
        check("lock_locked", 32'(bus.locked), 1);
        inc_base = inc_cnt;
        for (int i = 0; i < 3; i++) press(2'b01);
        check("lock_frozen_count", 32'(bus.count), 0);
        check("lock_frozen_inc",   32'(inc_cnt - inc_base), 0);
        check("lock_frozen_state", 32'(bus.state), 2);
        press(2'b10);
        check("unlock_state",  32'(bus.state), 0);
        check("unlock_locked", 32'(bus.locked), 0);
        press(2'b01);
        check("unlock_inc_count", 32'(bus.count), 1);

        // Simultaneous press: lock wins
        inc_base = inc_cnt;
        press(2'b00);
        check("simul_state",  32'(bus.state), 2);
        check("simul_count",  32'(bus.count), 1);
        check("simul_locked", 32'(bus.locked), 1);
        check("simul_inc",    32'(inc_cnt - inc_base), 0);

        // Async reset between edges
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_count",  32'(bus.count), 0);
        check("async_state",  32'(bus.state), 0);
        check("async_locked", 32'(bus.locked), 0);

        // Key held through reset release gives no press until released
        bus.key_n = 2'b01;
        step(3);
        rst = 1'b0;
        inc_base = inc_cnt;
        step(60);
        check("held_rst_count", 32'(bus.count), 0);
        check("held_rst_inc",   32'(inc_cnt - inc_base), 0);
        bus.key_n = 2'b11;
        step(30);
        press(2'b01);
        check("held_rst_after", 32'(bus.count), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
